// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU constants and types used by the register file and its read ports.
//   DATA_W   : general register width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   REG_ZERO : address of the hardwired-zero register
// ----------------------------------------------------------------------------
package cpu_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage : cpu_pkg

// File: rtl/regfile_read_port.sv
// ----------------------------------------------------------------------------
// regfile_read_port
// One combinational source-operand read port of the register file.
// Masks register 0 to zero and, when REG_BYPASS_EN is defined, forwards
// same-cycle write data (port 1 has priority over port 0).
// Ports:
//   rst         : asynchronous reset; forces the read data to zero
//   rd_addr     : read address
//   stored_data : storage contents at rd_addr
//   wr_en_0/1   : write enables, already qualified (nonzero address, not
//                 halted, not in reset)
//   wr_addr_0/1 : write addresses
//   wr_data_0/1 : write data
//   rd_data     : read result
// Optional feature macro: REG_BYPASS_EN
// ----------------------------------------------------------------------------
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              wr_en_0,
    input  logic [ADDR_W-1:0] wr_addr_0,
    input  logic [DATA_W-1:0] wr_data_0,
    input  logic              wr_en_1,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [DATA_W-1:0] wr_data_1,
    output logic [DATA_W-1:0] rd_data
);

`ifndef REG_BYPASS_EN
    // Write-side inputs only matter to the bypass path.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en_0, wr_addr_0, wr_data_0,
                             wr_en_1, wr_addr_1, wr_data_1};
`endif

    always_comb begin
        rd_data = stored_data;
`ifdef REG_BYPASS_EN
        // Port 1 is checked first so it wins when both ports hit rd_addr.
        if (wr_en_1 && (wr_addr_1 == rd_addr)) begin
            rd_data = wr_data_1;
        end else if (wr_en_0 && (wr_addr_0 == rd_addr)) begin
            rd_data = wr_data_0;
        end
`endif
        if (rst || (rd_addr == ADDR_W'(REG_ZERO))) begin
            rd_data = '0;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
// Architectural 32 x 16-bit general register file with two write ports,
// two combinational read ports and a sticky halt flag.
// Ports:
//   clk, rst                                  : clock, async active-high reset
//   dst_we_0, dst_addr_0, reg_0_wrt_data      : primary destination write
//   dst_we_1, dst_addr_1, reg_1_wrt_data      : secondary destination write
//                                               (SWAP / jump return); wins
//                                               on an address collision
//   MWB_halt                                  : halt from writeback stage
//   src_addr_0/1, src_data_0/1                : read ports A and B
//   halted                                    : sticky halt flag
// Optional feature macro: REG_BYPASS_EN (same-cycle write-through on reads)
// ----------------------------------------------------------------------------
module register_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dst_we_0,
    input  logic [ADDR_W-1:0] dst_addr_0,
    input  logic [DATA_W-1:0] reg_0_wrt_data,
    input  logic              dst_we_1,
    input  logic [ADDR_W-1:0] dst_addr_1,
    input  logic [DATA_W-1:0] reg_1_wrt_data,
    input  logic              MWB_halt,
    input  logic [ADDR_W-1:0] src_addr_0,
    input  logic [ADDR_W-1:0] src_addr_1,
    output logic [DATA_W-1:0] src_data_0,
    output logic [DATA_W-1:0] src_data_1,
    output logic              halted
);

    if (NUM_REGS != (2 ** ADDR_W)) begin : g_bad_size
        $error("register_file: NUM_REGS must equal 2**ADDR_W");
    end

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok_0;
    logic              wr_ok_1;

    // A write commits only to a nonzero address and only while not halted.
    // The instruction carrying MWB_halt still writes: halted is still 0 then.
    assign wr_ok_0 = dst_we_0 && (dst_addr_0 != ADDR_W'(REG_ZERO)) && !halted && !rst;
    assign wr_ok_1 = dst_we_1 && (dst_addr_1 != ADDR_W'(REG_ZERO)) && !halted && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_ok_0) begin
                regs[dst_addr_0] <= reg_0_wrt_data;
            end
            // Port 1 is assigned last so it overrides port 0 on a collision.
            if (wr_ok_1) begin
                regs[dst_addr_1] <= reg_1_wrt_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (MWB_halt) begin
            halted <= 1'b1;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_a (
        .rst         (rst),
        .rd_addr     (src_addr_0),
        .stored_data (regs[src_addr_0]),
        .wr_en_0     (wr_ok_0),
        .wr_addr_0   (dst_addr_0),
        .wr_data_0   (reg_0_wrt_data),
        .wr_en_1     (wr_ok_1),
        .wr_addr_1   (dst_addr_1),
        .wr_data_1   (reg_1_wrt_data),
        .rd_data     (src_data_0)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_b (
        .rst         (rst),
        .rd_addr     (src_addr_1),
        .stored_data (regs[src_addr_1]),
        .wr_en_0     (wr_ok_0),
        .wr_addr_0   (dst_addr_0),
        .wr_data_0   (reg_0_wrt_data),
        .wr_en_1     (wr_ok_1),
        .wr_addr_1   (dst_addr_1),
        .wr_data_1   (reg_1_wrt_data),
        .rd_data     (src_data_1)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
// Self-checking bench for register_file: vector table plus hand-written
// sequences for reset, bypass timing and halt.
// ----------------------------------------------------------------------------
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        dst_we_0;
    logic [4:0]  dst_addr_0;
    logic [15:0] reg_0_wrt_data;
    logic        dst_we_1;
    logic [4:0]  dst_addr_1;
    logic [15:0] reg_1_wrt_data;
    logic        MWB_halt;
    logic [4:0]  src_addr_0;
    logic [4:0]  src_addr_1;
    logic [15:0] src_data_0;
    logic [15:0] src_data_1;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk            (clk),
        .rst            (rst),
        .dst_we_0       (dst_we_0),
        .dst_addr_0     (dst_addr_0),
        .reg_0_wrt_data (reg_0_wrt_data),
        .dst_we_1       (dst_we_1),
        .dst_addr_1     (dst_addr_1),
        .reg_1_wrt_data (reg_1_wrt_data),
        .MWB_halt       (MWB_halt),
        .src_addr_0     (src_addr_0),
        .src_addr_1     (src_addr_1),
        .src_data_0     (src_data_0),
        .src_data_1     (src_data_1),
        .halted         (halted)
    );

    typedef struct {
        string       name;
        logic        we0;
        logic [4:0]  a0;
        logic [15:0] d0;
        logic        we1;
        logic [4:0]  a1;
        logic [15:0] d1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } sb_t;

    vec_t vecs [6];
    sb_t  sb_q [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_writes();
        dst_we_0 = 1'b0;
        dst_we_1 = 1'b0;
        MWB_halt = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        sb_t e;
        @(negedge clk);
        dst_we_0 = v.we0; dst_addr_0 = v.a0; reg_0_wrt_data = v.d0;
        dst_we_1 = v.we1; dst_addr_1 = v.a1; reg_1_wrt_data = v.d1;
        src_addr_0 = v.ra0; src_addr_1 = v.ra1;
        e.name = v.name; e.exp0 = v.exp0; e.exp1 = v.exp1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        idle_writes();
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 16'h0001, 16'h0000);
        end else begin
            e = sb_q.pop_front();
            chk({e.name, "_a"}, src_data_0, e.exp0);
            chk({e.name, "_b"}, src_data_1, e.exp1);
        end
    endtask

    initial begin
        vecs[0] = '{"wr_r3",    1, 5'd3,  16'h1234, 0, 5'd0,  16'h0000, 5'd3,  5'd3,  16'h1234, 16'h1234};
        vecs[1] = '{"r0_prot",  1, 5'd0,  16'hFFFF, 1, 5'd0,  16'hFFFF, 5'd0,  5'd3,  16'h0000, 16'h1234};
        vecs[2] = '{"conflict", 1, 5'd31, 16'hAAAA, 1, 5'd31, 16'h5555, 5'd31, 5'd0,  16'h5555, 16'h0000};
        vecs[3] = '{"preload",  1, 5'd1,  16'h0011, 1, 5'd2,  16'h0022, 5'd1,  5'd2,  16'h0011, 16'h0022};
        vecs[4] = '{"swap",     1, 5'd1,  16'h0022, 1, 5'd2,  16'h0011, 5'd1,  5'd2,  16'h0022, 16'h0011};
        vecs[5] = '{"p1_only",  0, 5'd7,  16'h1111, 1, 5'd7,  16'h7777, 5'd7,  5'd31, 16'h7777, 16'h5555};

        rst = 1'b1;
        idle_writes();
        dst_addr_0 = '0; reg_0_wrt_data = '0;
        dst_addr_1 = '0; reg_1_wrt_data = '0;
        src_addr_0 = 5'd5; src_addr_1 = 5'd31;
        #1;
        chk("reset_rd_a", src_data_0, 16'h0000);
        chk("reset_rd_b", src_data_1, 16'h0000);
        chk("reset_halted", {15'd0, halted}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Async reset mid-cycle clears storage immediately.
        apply_vec('{"wr_r5", 1, 5'd5, 16'hBEEF, 0, 5'd0, 16'h0000, 5'd5, 5'd5, 16'hBEEF, 16'hBEEF});
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rd", src_data_0, 16'h0000);
        chk("async_rst_halted", {15'd0, halted}, 16'h0000);
        // Write presented while in reset is discarded.
        @(negedge clk);
        dst_we_0 = 1'b1; dst_addr_0 = 5'd5; reg_0_wrt_data = 16'h1111;
        @(posedge clk);
        #1;
        idle_writes();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_discard_wr", src_data_0, 16'h0000);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Same-cycle read of a location being written.
        @(negedge clk);
        dst_we_0 = 1'b1; dst_addr_0 = 5'd6; reg_0_wrt_data = 16'h0606;
        dst_we_1 = 1'b1; dst_addr_1 = 5'd8; reg_1_wrt_data = 16'h0808;
        src_addr_0 = 5'd6; src_addr_1 = 5'd8;
        #1;
`ifdef REG_BYPASS_EN
        chk("bypass_pre_edge_a", src_data_0, 16'h0606);
        chk("bypass_pre_edge_b", src_data_1, 16'h0808);
`else
        chk("nobypass_pre_edge_a", src_data_0, 16'h0000);
        chk("nobypass_pre_edge_b", src_data_1, 16'h0000);
`endif
        @(posedge clk);
        #1;
        idle_writes();
        #1;
        chk("r6_post_edge", src_data_0, 16'h0606);
        chk("r8_post_edge", src_data_1, 16'h0808);

        // Collision on a read address: port 1 data is the one seen.
        @(negedge clk);
        dst_we_0 = 1'b1; dst_addr_0 = 5'd9; reg_0_wrt_data = 16'h0909;
        dst_we_1 = 1'b1; dst_addr_1 = 5'd9; reg_1_wrt_data = 16'h9090;
        src_addr_0 = 5'd9;
        #1;
`ifdef REG_BYPASS_EN
        chk("bypass_collide", src_data_0, 16'h9090);
`else
        chk("nobypass_collide", src_data_0, 16'h0000);
`endif
        @(posedge clk);
        #1;
        idle_writes();
        #1;
        chk("r9_post_edge", src_data_0, 16'h9090);

        // Halt: the carrying instruction still writes.
        @(negedge clk);
        dst_we_0 = 1'b1; dst_addr_0 = 5'd4; reg_0_wrt_data = 16'h0044;
        MWB_halt = 1'b1;
        src_addr_0 = 5'd4; src_addr_1 = 5'd6;
        @(posedge clk);
        #1;
        idle_writes();
        #1;
        chk("halt_edge_r4", src_data_0, 16'h0044);
        chk("halt_set", {15'd0, halted}, 16'h0001);

        // After halt all writes are blocked, and nothing is forwarded.
        @(negedge clk);
        dst_we_0 = 1'b1; dst_addr_0 = 5'd4; reg_0_wrt_data = 16'h9999;
        dst_we_1 = 1'b1; dst_addr_1 = 5'd6; reg_1_wrt_data = 16'h6666;
        #1;
        chk("halted_pre_edge_r4", src_data_0, 16'h0044);
        @(posedge clk);
        #1;
        idle_writes();
        #1;
        chk("halted_blk_r4", src_data_0, 16'h0044);
        chk("halted_blk_r6", src_data_1, 16'h0606);
        chk("halt_sticky", {15'd0, halted}, 16'h0001);

        // Reset releases halt and writes resume.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_clr_halt", {15'd0, halted}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        apply_vec('{"post_halt_wr", 1, 5'd4, 16'h4321, 0, 5'd0, 16'h0000, 5'd4, 5'd6, 16'h4321, 16'h0000});

        if (sb_q.size() != 0) chk("scoreboard_drain", 16'(sb_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural 32 x 16-bit general register file for the CPU.
- Sits directly downstream of the memory/writeback stage and consumes its two write ports: the primary destination and the secondary destination (SWAP / jump return).
- Supplies two combinational source-operand reads to the decode/execute stage.
- Latches the pipeline halt so the testbench and top level can observe CPU stop.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- dst_we_0  input  1  write enable, port 0 (primary destination)
- dst_addr_0  input  ADDR_W  write address, port 0
- reg_0_wrt_data  input  DATA_W  write data, port 0
- dst_we_1  input  1  write enable, port 1 (secondary destination)
- dst_addr_1  input  ADDR_W  write address, port 1
- reg_1_wrt_data  input  DATA_W  write data, port 1
- MWB_halt  input  1  halt indication from the writeback stage
- src_addr_0  input  ADDR_W  read address A
- src_addr_1  input  ADDR_W  read address B
- src_data_0  output  DATA_W  read data A
- src_data_1  output  DATA_W  read data B
- halted  output  1  sticky halt flag

Behaviour:
- Reset (asynchronous assert):
  - All NUM_REGS entries clear to 16'h0000 immediately.
  - halted clears to 0.
  - src_data_0/1 read 16'h0000 while rst is high.
  - Reset asserted mid-write discards that write.
- Register 0 is hardwired to zero:
  - Writes to address 0 on either port are ignored.
  - Reads of address 0 always return 16'h0000.
- Writes: on the rising edge, each port with we=1 and addr!=0 updates its entry. Latency is 1 cycle to storage.
- Simultaneous writes:
  - Different addresses: both writes commit in the same edge (SWAP case).
  - Same address: port 1 wins. The J/JI return-address write has priority over the primary result.
- Reads:
  - Asynchronous and combinational from storage.
  - No read-during-write forwarding unless REG_BYPASS_EN is defined.
  - Without the bypass, a read of an address being written this cycle returns the old value; the new value is visible after the edge.
- Halt:
  - MWB_halt=1 sampled at an edge sets halted=1 from that edge onward.
  - halted is sticky until rst.
  - Once halted=1, all writes are blocked, including writes coincident with the setting edge after halted is already high.
  - The instruction carrying MWB_halt itself still writes if its we bits are set.
  - Reads remain functional while halted.
- Enable and address inputs are fully decoded. Out-of-range addresses cannot occur because NUM_REGS = 2**ADDR_W.

Optional Feature:
- Macro: REG_BYPASS_EN.
- Defined:
  - A write-through path forwards same-cycle write data to a read port when the read address equals an enabled, nonzero write address and halted=0.
  - When both write ports target that address, port 1 data is forwarded.
  - Zero-cycle forwarding removes one hazard bubble in the decode/execute stage.
- Undefined: reads return storage contents only, as above.

Decomposition:
- Shared package cpu_pkg holds:
  - constants DATA_W=16, ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0
  - typedefs reg_data_t (16-bit) and reg_addr_t (5-bit)
- One natural sub-module, regfile_read_port:
  - One instance per read port.
  - Contains the address-0 masking and the optional bypass mux, so both ports share identical logic.
- Storage and write arbitration stay in the top module.

Test Plan:
- Reset clears storage: write 16'hBEEF to R5, assert rst asynchronously mid-cycle -> src_data_0 with src_addr_0=5 reads 16'h0000 immediately; halted=0.
- Basic write then read: write R3=16'h1234 on port 0 -> after the edge, src_data_1 (addr 3) = 16'h1234.
- R0 protection: write R0=16'hFFFF via both ports -> src_data_0 (addr 0) = 16'h0000.
- Dual write conflict: port 0 writes R31=16'hAAAA and port 1 writes R31=16'h5555 in the same cycle -> R31 = 16'h5555.
- SWAP: R1=16'h0011 and R2=16'h0022 preloaded; same-cycle port 0 R1<=16'h0022 and port 1 R2<=16'h0011 -> R1=16'h0022, R2=16'h0011.
- Halt and bypass:
  - Same edge: MWB_halt=1 with port 0 write R4=16'h0044 -> R4=16'h0044 and halted=1.
  - Next cycle: write R4=16'h9999 -> R4 stays 16'h0044.
  - With REG_BYPASS_EN, before the halt: same-cycle write R6=16'h0606 with src_addr_0=6 -> src_data_0 = 16'h0606 before the edge.
  - Without REG_BYPASS_EN, same stimulus: src_data_0 shows the old value until the edge.
